// File: rtl/dual_port_router_arb.sv
// Dual-port router arbitration core: two valid/ready inputs, four registered output lanes, APB-like config port.
// Optional starvation guard is compiled in when ROUTER_ARB_STARVE_GUARD_EN is defined.
module dual_port_router_arb #(
  parameter int REG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       reg_addr,
  input  logic [REG_W-1:0] reg_wdata,
  input  logic             reg_en,
  input  logic             reg_we,
  output logic [REG_W-1:0] reg_rdata,
  input  logic [7:0]       data_a,
  input  logic [1:0]       addr_a,
  input  logic             valid_a,
  output logic             ready_a,
  input  logic [7:0]       data_b,
  input  logic [1:0]       addr_b,
  input  logic             valid_b,
  output logic             ready_b,
  output logic [31:0]      data_out,
  output logic [3:0]       valid_out
);

  typedef enum logic [1:0] {DIS = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_e;

  logic [1:0]       ctrl_q, ctrl_d;
  logic [7:0]       wgtA_q, wgtA_d, wgtB_q, wgtB_d;
  logic [3:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cntA_q, cntA_d, cntB_q, cntB_d, cntDrop_q, cntDrop_d;
  logic [CNT_W:0]   dropSum;
  state_e           state_q, state_d;
  logic [7:0]       credit_q, credit_d;
  logic [REG_W-1:0] rdata_q, rdata_d;
  logic [31:0]      dataOut_q, dataOut_d;
  logic [3:0]       validOut_q, validOut_d;

  logic [3:0] starveCnt;
  logic       starveClr, starveInc, starveFull;

  logic       regWr, regRd, enable, wrr, ownerB, conflict, forceWin, bWins;
  logic       delA, delB, dropA, dropB;
  logic [7:0] loadA, loadB;
  logic       unusedWdata;

  assign regWr       = reg_en & reg_we;
  assign regRd       = reg_en & ~reg_we;
  assign unusedWdata = ^reg_wdata[REG_W-1:8];

  assign enable   = ctrl_q[0];
  assign wrr      = ctrl_q[1];
  assign ownerB   = (state_q == OWN_B);
  assign loadA    = (wgtA_q == 8'd0) ? 8'd1 : wgtA_q;
  assign loadB    = (wgtB_q == 8'd0) ? 8'd1 : wgtB_q;

  // Only a same-lane collision on an enabled lane needs a winner; masked lanes swallow both packets.
  assign conflict   = enable & valid_a & valid_b & (addr_a == addr_b) & mask_q[addr_a];
  assign starveFull = (starveCnt == 4'hF);
  assign forceWin   = wrr & conflict & starveFull;
  assign bWins      = wrr & (ownerB ^ forceWin);

  assign ready_a = enable & valid_a & ~(conflict & bWins);
  assign ready_b = enable & valid_b & ~(conflict & ~bWins);

  assign delA  = ready_a & mask_q[addr_a];
  assign delB  = ready_b & mask_q[addr_b];
  assign dropA = ready_a & ~mask_q[addr_a];
  assign dropB = ready_b & ~mask_q[addr_b];

  always_comb begin
    ctrl_d = ctrl_q;
    wgtA_d = wgtA_q;
    wgtB_d = wgtB_q;
    mask_d = mask_q;
    if (regWr) begin
      case (reg_addr)
        4'h0:    ctrl_d = reg_wdata[1:0];
        4'h1:    wgtA_d = reg_wdata[7:0];
        4'h2:    wgtB_d = reg_wdata[7:0];
        4'h3:    mask_d = reg_wdata[3:0];
        default: ;
      endcase
    end
  end

  // FSM follows the CTRL value being written so enabling or a mode switch lands on OWN_A at the same edge.
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    starveClr = 1'b0;
    starveInc = 1'b0;
    if (!ctrl_d[0]) begin
      state_d   = DIS;
      credit_d  = 8'd0;
      starveClr = 1'b1;
    end else if (state_q == DIS || ctrl_d[1] != ctrl_q[1]) begin
      state_d   = OWN_A;
      credit_d  = loadA;
      starveClr = 1'b1;
    end else if (wrr && conflict) begin
      if (forceWin || credit_q <= 8'd1) begin
        state_d   = ownerB ? OWN_A : OWN_B;
        credit_d  = ownerB ? loadA : loadB;
        starveClr = 1'b1;
      end else begin
        credit_d  = credit_q - 8'd1;
        starveInc = 1'b1;
      end
    end
  end

  always_comb begin
    cntA_d    = cntA_q;
    cntB_d    = cntB_q;
    if (delA && !(&cntA_q)) cntA_d = cntA_q + CNT_W'(1);
    if (delB && !(&cntB_q)) cntB_d = cntB_q + CNT_W'(1);
    dropSum   = {1'b0, cntDrop_q} + (CNT_W+1)'(dropA) + (CNT_W+1)'(dropB);
    cntDrop_d = dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
    if (regWr) begin
      case (reg_addr)
        4'h4:    cntA_d    = '0;
        4'h5:    cntB_d    = '0;
        4'h6:    cntDrop_d = '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (regRd) begin
      rdata_d = '0;
      case (reg_addr)
        4'h0: rdata_d[1:0]       = ctrl_q;
        4'h1: rdata_d[7:0]       = wgtA_q;
        4'h2: rdata_d[7:0]       = wgtB_q;
        4'h3: rdata_d[3:0]       = mask_q;
        4'h4: rdata_d[CNT_W-1:0] = cntA_q;
        4'h5: rdata_d[CNT_W-1:0] = cntB_q;
        4'h6: rdata_d[CNT_W-1:0] = cntDrop_q;
        4'h7: begin
          rdata_d[1:0]   = state_q;
          rdata_d[9:2]   = credit_q;
          rdata_d[13:10] = starveCnt;
        end
        default: ;
      endcase
    end
  end

  // A and B never deliver to the same lane in one cycle, so the two writes cannot collide.
  always_comb begin
    dataOut_d  = dataOut_q;
    validOut_d = 4'd0;
    if (delA) begin
      validOut_d[addr_a]               = 1'b1;
      dataOut_d[{addr_a, 3'b000} +: 8] = data_a;
    end
    if (delB) begin
      validOut_d[addr_b]               = 1'b1;
      dataOut_d[{addr_b, 3'b000} +: 8] = data_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= 2'd0;
      wgtA_q     <= 8'd1;
      wgtB_q     <= 8'd1;
      mask_q     <= 4'hF;
      cntA_q     <= '0;
      cntB_q     <= '0;
      cntDrop_q  <= '0;
      state_q    <= DIS;
      credit_q   <= 8'd0;
      rdata_q    <= '0;
      dataOut_q  <= 32'd0;
      validOut_q <= 4'd0;
    end else begin
      ctrl_q     <= ctrl_d;
      wgtA_q     <= wgtA_d;
      wgtB_q     <= wgtB_d;
      mask_q     <= mask_d;
      cntA_q     <= cntA_d;
      cntB_q     <= cntB_d;
      cntDrop_q  <= cntDrop_d;
      state_q    <= state_d;
      credit_q   <= credit_d;
      rdata_q    <= rdata_d;
      dataOut_q  <= dataOut_d;
      validOut_q <= validOut_d;
    end
  end

`ifdef ROUTER_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  // Counts consecutive conflicts lost by the non-owner; at 15 the next conflict is handed over.
  always_comb begin
    starve_d = starve_q;
    if (starveClr) starve_d = 4'd0;
    else if (starveInc) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= 4'd0;
    else     starve_q <= starve_d;
  end

  assign starveCnt = starve_q;
`else
  logic unusedStarve;
  assign unusedStarve = starveClr ^ starveInc;
  assign starveCnt    = 4'd0;
`endif

  assign reg_rdata = rdata_q;
  assign data_out  = dataOut_q;
  assign valid_out = validOut_q;

endmodule

// File: tb/tb_dual_port_router_arb.sv
// Self-checking bench for dual_port_router_arb: directed vectors, literal checks and a per-cycle reference model.
module tb_dual_port_router_arb;
  localparam int REG_W   = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ROUTER_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       reg_addr;
  logic [REG_W-1:0] reg_wdata;
  logic             reg_en, reg_we;
  logic [REG_W-1:0] reg_rdata;
  logic [7:0]       data_a, data_b;
  logic [1:0]       addr_a, addr_b;
  logic             valid_a, valid_b, ready_a, ready_b;
  logic [31:0]      data_out;
  logic [3:0]       valid_out;

  dual_port_router_arb #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_en(reg_en), .reg_we(reg_we), .reg_rdata(reg_rdata),
    .data_a(data_a), .addr_a(addr_a), .valid_a(valid_a), .ready_a(ready_a),
    .data_b(data_b), .addr_b(addr_b), .valid_b(valid_b), .ready_b(ready_b),
    .data_out(data_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state: plain integers describing what the router should be doing.
  bit          mEn, mMode, mActive, mOwnerB;
  int          mWgtA, mWgtB, mCntA, mCntB, mDrop, mCredit, mWait;
  logic [3:0]  mMask, mValid;
  logic [31:0] mRdata, mData;

  int expWinA[6]  = '{1, 1, 0, 1, 1, 0};
  int expCred[6]  = '{2, 1, 1, 2, 1, 1};
  int expState[6] = '{1, 1, 2, 1, 1, 2};
  int expAlt[4]   = '{1, 0, 1, 0};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wload(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic logic [31:0] modelRead(input int a);
    int st;
    st = !mActive ? 0 : (mOwnerB ? 2 : 1);
    case (a)
      0:       return {30'd0, mMode, mEn};
      1:       return 32'(mWgtA);
      2:       return 32'(mWgtB);
      3:       return {28'd0, mMask};
      4:       return 32'(mCntA);
      5:       return 32'(mCntB);
      6:       return 32'(mDrop);
      7:       return 32'((GUARD ? mWait : 0) * 1024 + mCredit * 4 + st);
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    mEn = 0; mMode = 0; mActive = 0; mOwnerB = 0;
    mWgtA = 1; mWgtB = 1; mCntA = 0; mCntB = 0; mDrop = 0; mCredit = 0; mWait = 0;
    mMask = 4'hF; mValid = 4'd0; mRdata = 32'd0; mData = 32'd0;
  endtask

  task automatic modelStep();
    int la, lb, wa;
    bit conflict, forced, bWin, ra, rb, newEn, newMode;
    la = int'(addr_a);
    lb = int'(addr_b);
    conflict = mEn && valid_a && valid_b && (la == lb) && mMask[la];
    forced   = GUARD && mMode && conflict && (mWait == 15);
    bWin     = mMode && (mOwnerB != forced);
    ra = mEn && valid_a && !(conflict && bWin);
    rb = mEn && valid_b && !(conflict && !bWin);
    if (valid_a) checkOutput("readyA", 32'(ready_a), 32'(ra));
    if (valid_b) checkOutput("readyB", 32'(ready_b), 32'(rb));
    if (reg_en && !reg_we) mRdata = modelRead(int'(reg_addr));
    mValid = 4'd0;
    if (ra) begin
      if (mMask[la]) begin mValid[la] = 1'b1; mData[la*8 +: 8] = data_a; mCntA = sat(mCntA + 1); end
      else mDrop = sat(mDrop + 1);
    end
    if (rb) begin
      if (mMask[lb]) begin mValid[lb] = 1'b1; mData[lb*8 +: 8] = data_b; mCntB = sat(mCntB + 1); end
      else mDrop = sat(mDrop + 1);
    end
    wa = int'(reg_addr);
    newEn   = (reg_en && reg_we && wa == 0) ? reg_wdata[0] : mEn;
    newMode = (reg_en && reg_we && wa == 0) ? reg_wdata[1] : mMode;
    if (!newEn) begin
      mActive = 0; mOwnerB = 0; mCredit = 0; mWait = 0;
    end else if (!mActive || newMode != mMode) begin
      mActive = 1; mOwnerB = 0; mCredit = wload(mWgtA); mWait = 0;
    end else if (mMode && conflict) begin
      if (forced || mCredit == 1) begin
        mOwnerB = !mOwnerB;
        mCredit = mOwnerB ? wload(mWgtB) : wload(mWgtA);
        mWait   = 0;
      end else begin
        mCredit = mCredit - 1;
        if (GUARD) mWait = mWait + 1;
      end
    end
    if (reg_en && reg_we) begin
      case (wa)
        0: begin mEn = reg_wdata[0]; mMode = reg_wdata[1]; end
        1: mWgtA = int'(reg_wdata[7:0]);
        2: mWgtB = int'(reg_wdata[7:0]);
        3: mMask = reg_wdata[3:0];
        4: mCntA = 0;
        5: mCntB = 0;
        6: mDrop = 0;
        default: ;
      endcase
    end
  endtask

  // Compare process: outputs registered at the last edge against the model, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      modelReset();
      checkOutput("rstValidOut", 32'(valid_out), 32'd0);
      checkOutput("rstRdata", reg_rdata, 32'd0);
      checkOutput("rstReadyA", 32'(ready_a), 32'd0);
    end else begin
      checkOutput("validOut", 32'(valid_out), 32'(mValid));
      checkOutput("dataOut", data_out, mData);
      checkOutput("regRdata", reg_rdata, mRdata);
      modelStep();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit va, input logic [1:0] aa, input logic [7:0] da,
                               input bit vb, input logic [1:0] ab, input logic [7:0] db);
    valid_a = va; addr_a = aa; data_a = da;
    valid_b = vb; addr_b = ab; data_b = db;
  endtask

  task automatic regWrite(input logic [3:0] a, input logic [31:0] d);
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic regRead(input logic [3:0] a, output logic [31:0] d);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = a;
    tick();
    reg_en = 1'b0;
    d = reg_rdata;
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1;
    reg_addr = 4'd0; reg_wdata = 32'd0; reg_en = 1'b0; reg_we = 1'b0;
    applyStimulus(1, 2'd1, 8'hAA, 0, 2'd0, 8'h00);
    tick(); tick();
    checkOutput("resetReadyA", 32'(ready_a), 32'd0);
    checkOutput("resetValidOut", 32'(valid_out), 32'd0);
    checkOutput("resetDataOut", data_out, 32'd0);
    rst = 1'b0;
    applyStimulus(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    tick();

    // Distinct lanes in fixed-priority mode
    regWrite(4'h0, 32'h1);
    applyStimulus(1, 2'd1, 8'h11, 1, 2'd2, 8'h22);
    #1;
    checkOutput("distinctReadyA", 32'(ready_a), 32'd1);
    checkOutput("distinctReadyB", 32'(ready_b), 32'd1);
    tick();
    applyStimulus(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    checkOutput("distinctValid", 32'(valid_out), 32'h6);
    checkOutput("distinctLane1", 32'(data_out[15:8]), 32'h11);
    checkOutput("distinctLane2", 32'(data_out[23:16]), 32'h22);
    tick();
    checkOutput("pulseEnds", 32'(valid_out), 32'h0);
    checkOutput("dataHolds", 32'(data_out[15:8]), 32'h11);

    // Fixed priority conflict on lane 3
    regWrite(4'h4, 32'h0);
    regWrite(4'h5, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2'd3, 8'(32'h30 + i), 1, 2'd3, 8'(32'h40 + i));
      #1;
      checkOutput("fixedReadyA", 32'(ready_a), 32'd1);
      checkOutput("fixedReadyB", 32'(ready_b), 32'd0);
      tick();
    end
    applyStimulus(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    tick();
    regRead(4'h4, rd); checkOutput("cntA4", rd, 32'd4);
    regRead(4'h5, rd); checkOutput("cntB0", rd, 32'd0);

    // Saturation of CNT_A at all-ones
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 2'd0, 8'(i), 0, 2'd0, 8'h00);
      tick();
    end
    applyStimulus(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    tick();
    regRead(4'h4, rd); checkOutput("cntASat", rd, 32'(CNT_MAX));

    // Weighted round-robin with WGT_A=2, WGT_B=1
    regWrite(4'h1, 32'd2);
    regWrite(4'h2, 32'd1);
    regWrite(4'h0, 32'h3);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = 4'h7;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 2'd0, 8'(32'hA0 + i), 1, 2'd0, 8'(32'hB0 + i));
      #1;
      checkOutput("wrrWinA", 32'(ready_a), 32'(expWinA[i]));
      tick();
      checkOutput("wrrCredit", 32'(reg_rdata[9:2]), 32'(expCred[i]));
      checkOutput("wrrState", 32'(reg_rdata[1:0]), 32'(expState[i]));
    end
    reg_en = 1'b0;
    applyStimulus(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    tick();

    // Masked lane drops
    regWrite(4'h0, 32'h1);
    regWrite(4'h3, 32'hE);
    regWrite(4'h6, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'd0, 8'(32'hC0 + i), 0, 2'd0, 8'h00);
      #1;
      checkOutput("dropReadyA", 32'(ready_a), 32'd1);
      tick();
      checkOutput("dropNoValid", 32'(valid_out), 32'd0);
    end
    applyStimulus(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    tick();
    regRead(4'h6, rd); checkOutput("cntDrop3", rd, 32'd3);
    applyStimulus(1, 2'd0, 8'hD1, 1, 2'd0, 8'hD2);
    #1;
    checkOutput("dualDropA", 32'(ready_a), 32'd1);
    checkOutput("dualDropB", 32'(ready_b), 32'd1);
    tick();
    applyStimulus(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    regRead(4'h6, rd); checkOutput("cntDrop5", rd, 32'd5);
    regWrite(4'h6, 32'h7B);
    regRead(4'h6, rd); checkOutput("cntDropClr", rd, 32'd0);
    regWrite(4'h9, 32'hFFFF);
    regRead(4'h9, rd); checkOutput("unmapped", rd, 32'd0);
    regWrite(4'h3, 32'hF);

    // Asynchronous reset during a transfer
    applyStimulus(1, 2'd2, 8'h5A, 0, 2'd0, 8'h00);
    tick();
    checkOutput("preResetValid", 32'(valid_out), 32'h4);
    rst = 1'b1;
    #1;
    checkOutput("asyncValidClr", 32'(valid_out), 32'd0);
    applyStimulus(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    tick();
    rst = 1'b0;
    regRead(4'h0, rd); checkOutput("postRstCtrl", rd, 32'd0);
    regRead(4'h1, rd); checkOutput("postRstWgtA", rd, 32'd1);
    regRead(4'h3, rd); checkOutput("postRstMask", rd, 32'hF);

    // Zero weights behave as one: strict alternation
    regWrite(4'h1, 32'd0);
    regWrite(4'h2, 32'd0);
    regWrite(4'h0, 32'h3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2'd1, 8'(32'hE0 + i), 1, 2'd1, 8'(32'hF0 + i));
      #1;
      checkOutput("zeroWgtWinA", 32'(ready_a), 32'(expAlt[i]));
      tick();
    end
    applyStimulus(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);

    // Long owner weight: guard hands lane to B on the 16th conflict
    regWrite(4'h0, 32'h0);
    regWrite(4'h1, 32'd255);
    regWrite(4'h2, 32'd1);
    regWrite(4'h0, 32'h3);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 2'd2, 8'(i), 1, 2'd2, 8'(32'h80 + i));
      #1;
      checkOutput("guardReadyB", 32'(ready_b), (GUARD && i == 15) ? 32'd1 : 32'd0);
      tick();
    end
    applyStimulus(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    regRead(4'h7, rd);
    checkOutput("guardStatus", rd, GUARD ? 32'h6 : 32'h3BD);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
